// File: rtl/sma_generator_pkg.sv
// Shared types and constants for the SMA producer: window lengths, exact
// reciprocals for the per-window floor division, and FSM state encoding.
package sma_pkg;
  localparam int DATA_WIDTH  = 8;
  localparam int NUM_WIN     = 6;
  localparam int SUM_W       = 16;
  localparam int CNT_W       = 8;
  localparam int WARM_CNT    = 200;
  localparam int RECIP_SHIFT = 24;
  localparam int RECIP_W     = 22;

  typedef logic [DATA_WIDTH-1:0] price_t;
  typedef logic [SUM_W-1:0]      sum_t;
  typedef logic [2:0]            win_idx_t;

  typedef enum logic [1:0] {IDLE, UPDATE, PUBLISH} sma_state_t;

  localparam logic [7:0] WIN_LEN [NUM_WIN] = '{8'd5, 8'd10, 8'd20, 8'd50, 8'd100, 8'd200};

  // ceil(2^24/N): the rounding error e=M*N-2^24 is < N <= 200, so x*e < 2^24
  // for every sum x <= 51000, which makes (x*M)>>24 exactly floor(x/N).
  localparam logic [RECIP_W-1:0] WIN_RECIP [NUM_WIN] =
    '{22'd3355444, 22'd1677722, 22'd838861, 22'd335545, 22'd167773, 22'd83887};

  function automatic price_t win_avg(input sum_t s, input win_idx_t k);
    logic [SUM_W+RECIP_W-1:0] prod;
    prod = s * WIN_RECIP[k];
    return price_t'(prod >> RECIP_SHIFT);
  endfunction
endpackage

// File: rtl/sma_generator_if.sv
// Price input handshake plus the published SMA set; master is the producer.
interface sma_generator_if;
  import sma_pkg::*;
  logic   price_valid;
  price_t price;
  logic   price_ready;
  price_t data_5;
  price_t data_10;
  price_t data_20;
  price_t data_50;
  price_t data_100;
  price_t data_200;
  logic   data_valid_pre;
  logic   sma_warm;

  modport master (
    input  price_valid, price,
    output price_ready, data_5, data_10, data_20, data_50, data_100, data_200,
           data_valid_pre, sma_warm
  );
  modport slave (
    output price_valid, price,
    input  price_ready, data_5, data_10, data_20, data_50, data_100, data_200,
           data_valid_pre, sma_warm
  );
endinterface

// File: rtl/sma_history_ram.sv
// Price history: one synchronous write port, one combinational read port.
// Contents are never reset; the sample count decides which entries are live.
module sma_history_ram
  import sma_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  price_t                   wr_dat,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output price_t                   rd_dat
);
  price_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  assign rd_dat = mem[rd_addr];
endmodule

// File: rtl/sma_generator.sv
// 5/10/20/50/100/200-sample moving averages over an 8-bit price stream.
// Strobe 7 clocks after accept; price_ready is low for 8 clocks per sample.
module sma_generator
  import sma_pkg::*;
#(
  parameter int HIST_DEPTH = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  sma_generator_if.master sma
);
  localparam int AW = $clog2(HIST_DEPTH);
  typedef logic [AW-1:0] addr_t;

  // Saturates one past the longest window so the 200 window keeps retiring samples.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WARM_CNT + 1);

  sma_state_t       state_q, state_d;
  win_idx_t         k_q, k_d;
  addr_t            wp_q, wp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  price_t           price_q, price_d;
  sum_t             sum_q [NUM_WIN];
  sum_t             sum_d [NUM_WIN];
  price_t           shadow_q [NUM_WIN];
  price_t           shadow_d [NUM_WIN];
  price_t           data_q [NUM_WIN];
  price_t           data_d [NUM_WIN];
  logic             vld_q, vld_d;
  logic             warm_q, warm_d;

  logic       accept;
  addr_t      rd_addr;
  price_t     rd_dat;
  price_t     leaving;
  sum_t       sum_new;
  logic [7:0] win_n;

  assign sma.price_ready = (state_q == IDLE) && !vld_q;
  assign accept          = sma.price_valid && sma.price_ready;

  sma_history_ram #(.DEPTH(HIST_DEPTH)) u_ram (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (wp_q),
    .wr_dat  (sma.price),
    .rd_addr (rd_addr),
    .rd_dat  (rd_dat)
  );

  always_comb begin
    win_n    = WIN_LEN[k_q];
    rd_addr  = wp_q - addr_t'(1) - addr_t'(win_n);
    leaving  = (cnt_q > win_n) ? rd_dat : '0;
    sum_new  = sum_q[k_q] + sum_t'(price_q) - sum_t'(leaving);

    state_d  = state_q;
    k_d      = k_q;
    wp_d     = wp_q;
    cnt_d    = cnt_q;
    price_d  = price_q;
    sum_d    = sum_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    vld_d    = 1'b0;
    warm_d   = warm_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          wp_d    = wp_q + addr_t'(1);
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
          price_d = sma.price;
          k_d     = '0;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        sum_d[k_q]    = sum_new;
        shadow_d[k_q] = win_avg(sum_new, k_q);
        if (k_q == win_idx_t'(NUM_WIN - 1)) state_d = PUBLISH;
        else                                k_d     = k_q + win_idx_t'(1);
      end
      PUBLISH: begin
        data_d  = shadow_q;
        vld_d   = 1'b1;
        warm_d  = (cnt_q >= CNT_W'(WARM_CNT));
        k_d     = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      wp_q     <= '0;
      cnt_q    <= '0;
      price_q  <= '0;
      sum_q    <= '{default: '0};
      shadow_q <= '{default: '0};
      data_q   <= '{default: '0};
      vld_q    <= 1'b0;
      warm_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      wp_q     <= wp_d;
      cnt_q    <= cnt_d;
      price_q  <= price_d;
      sum_q    <= sum_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      vld_q    <= vld_d;
      warm_q   <= warm_d;
    end
  end

  assign sma.data_5         = data_q[0];
  assign sma.data_10        = data_q[1];
  assign sma.data_20        = data_q[2];
  assign sma.data_50        = data_q[3];
  assign sma.data_100       = data_q[4];
  assign sma.data_200       = data_q[5];
  assign sma.data_valid_pre = vld_q;
  assign sma.sma_warm       = warm_q;
endmodule

// File: tb/tb_sma_generator.sv
// Directed bench for sma_generator: reset, handshake/latency, warm-up, step,
// pointer wrap against a floor-average model, and reset during an update.
module tb_sma_generator;
  logic clk;
  logic rst_n;
  sma_generator_if sif ();

  sma_generator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sma   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int hist[$];
  int win_len [6] = '{5, 10, 20, 50, 100, 200};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dout(input int idx);
    case (idx)
      0:       return 32'(sif.data_5);
      1:       return 32'(sif.data_10);
      2:       return 32'(sif.data_20);
      3:       return 32'(sif.data_50);
      4:       return 32'(sif.data_100);
      default: return 32'(sif.data_200);
    endcase
  endfunction

  function automatic int model_avg(input int n);
    int s = 0;
    int m = hist.size();
    for (int i = 0; i < n && i < m; i++) s += hist[m-1-i];
    return s / n;
  endfunction

  // Drives one sample, returns at the negedge where the strobe is expected.
  task automatic send(input int p);
    int g;
    int lat;
    @(negedge clk);
    sif.price_valid = 1'b1;
    sif.price       = 8'(p);
    g = 0;
    while (!sif.price_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("ready_seen", 32'(sif.price_ready), 32'd1);
    @(posedge clk);
    hist.push_back(p & 255);
    #1 sif.price_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!sif.data_valid_pre && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 7);
  endtask

  task automatic idle_no_strobe(input int n, input string tag);
    int nstb = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (sif.data_valid_pre) nstb++;
    end
    chk(tag, nstb, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hist.delete();
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int nrdy;
    int nstb;
    int first;
    logic [31:0] d5;
    logic [31:0] d200;

    // 1: reset state
    rst_n           = 1'b0;
    sif.price_valid = 1'b0;
    sif.price       = '0;
    repeat (3) @(negedge clk);
    chk("rst_data_5", dout(0), 0);
    chk("rst_data_200", dout(5), 0);
    chk("rst_strobe", 32'(sif.data_valid_pre), 0);
    chk("rst_ready", 32'(sif.price_ready), 1);
    chk("rst_warm", 32'(sif.sma_warm), 0);
    rst_n = 1'b1;
    idle_no_strobe(10, "idle_after_rst");

    // 2: price_valid held through the busy window -> exactly one accept
    @(negedge clk);
    sif.price_valid = 1'b1;
    sif.price       = 8'd100;
    @(posedge clk);
    nrdy = 0; nstb = 0; first = -1; d5 = '0; d200 = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (!sif.price_ready) nrdy++;
      if (sif.data_valid_pre) begin
        nstb++;
        if (first < 0) first = c;
      end
      if (c == 7) begin
        d5   = dout(0);
        d200 = dout(5);
        sif.price_valid = 1'b0;
      end
    end
    chk("hs_ready_low_cycles", nrdy, 8);
    chk("hs_strobe_count", nstb, 1);
    chk("hs_strobe_cycle", first, 7);
    chk("hs_data_5", d5, 20);
    chk("hs_data_200", d200, 0);
    @(negedge clk);
    chk("hs_ready_back", 32'(sif.price_ready), 1);
    idle_no_strobe(10, "hs_no_second_accept");

    // 3: constant 100 warm-up from a clean start
    do_reset();
    for (int i = 1; i <= 200; i++) begin
      send(100);
      if (i == 5) begin
        chk("c100_s5_data_5", dout(0), 100);
        chk("c100_s5_data_10", dout(1), 50);
      end
      if (i == 199) chk("c100_s199_warm", 32'(sif.sma_warm), 0);
    end
    for (int w = 0; w < 6; w++) chk($sformatf("c100_s200_w%0d", win_len[w]), dout(w), 100);
    chk("c100_s200_warm", 32'(sif.sma_warm), 1);

    // 4: full-scale window, then a step down to zero
    for (int i = 0; i < 200; i++) send(255);
    chk("max_sum_data_200", dout(5), 255);
    chk("max_sum_data_5", dout(0), 255);
    for (int i = 0; i < 5; i++) send(0);
    chk("step_data_5", dout(0), 0);
    chk("step_data_10", dout(1), 127);
    chk("step_data_20", dout(2), 191);
    chk("step_data_50", dout(3), 229);
    chk("step_data_100", dout(4), 242);
    chk("step_data_200", dout(5), 248);

    // 5: pointer wraps more than twice; every strobe against the model
    for (int i = 0; i < 600; i++) begin
      send((7 * i) % 256);
      for (int w = 0; w < 6; w++)
        chk($sformatf("wrap_i%0d_w%0d", i, win_len[w]), dout(w), 32'(model_avg(win_len[w])));
    end
    chk("wrap_warm", 32'(sif.sma_warm), 1);

    // 6: reset while the k=3 window is being updated
    @(negedge clk);
    sif.price_valid = 1'b1;
    sif.price       = 8'd77;
    @(posedge clk);
    #1 sif.price_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_data_5", dout(0), 0);
    chk("midrst_data_200", dout(5), 0);
    chk("midrst_strobe", 32'(sif.data_valid_pre), 0);
    chk("midrst_warm", 32'(sif.sma_warm), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hist.delete();
    idle_no_strobe(12, "midrst_no_strobe");
    send(50);
    chk("post_rst_data_5", dout(0), 10);
    chk("post_rst_data_10", dout(1), 5);
    chk("post_rst_data_200", dout(5), 0);
    chk("post_rst_warm", 32'(sif.sma_warm), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
